// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    localparam int WORD_W = 32;
    localparam int MASK_W = 4;

    // Error cause bit positions inside the latched cause vector
    localparam int ERR_W        = 3;
    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_RDWR     = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Address-derived error causes; the read+write clash bit is filled in by the caller.
    function automatic logic [ERR_W-1:0] addr_err(input logic [31:0] addr, input int depth);
        logic [ERR_W-1:0] cause;
        logic [31:0]      word;
        cause               = '0;
        word                = {2'b00, addr[31:2]};
        cause[ERR_MISALIGN] = (addr[1:0] != 2'b00);
        cause[ERR_RANGE]    = (word >= $unsigned(depth));
        return cause;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bundle between the EX/MEM stage (master) and the responder (slave).
interface dmem_if;
    import dmem_pkg::*;

    logic                 i_req_vld;
    logic                 i_req_ren;
    logic                 i_req_wen;
    logic [31:0]          i_req_addr;
    logic [WORD_W-1:0]    i_req_wdata;
    logic [MASK_W-1:0]    i_req_mask;
    logic                 o_busy;
    logic                 o_rsp_vld;
    logic [WORD_W-1:0]    o_rsp_rdata;
    logic                 o_rsp_err;

    modport master (
        output i_req_vld, i_req_ren, i_req_wen, i_req_addr, i_req_wdata, i_req_mask,
        input  o_busy, o_rsp_vld, o_rsp_rdata, o_rsp_err
    );

    modport slave (
        input  i_req_vld, i_req_ren, i_req_wen, i_req_addr, i_req_wdata, i_req_mask,
        output o_busy, o_rsp_vld, o_rsp_rdata, o_rsp_err
    );

endinterface

// File: rtl/dmem_bank.sv
// Word-addressed SRAM split into byte lanes, synchronous byte-enable write, registered read.
module dmem_bank
    import dmem_pkg::*;
#(
    parameter  int DEPTH = 1024,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [MASK_W-1:0] i_mask,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_rdata
);

    // One narrow array per lane keeps each lane a plain single-port RAM.
    for (genvar gi = 0; gi < MASK_W; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] lane_rdata_reg;

        // Lane write on its mask bit; read data refreshes only on loads and holds otherwise
        always_ff @(posedge i_clk) begin
            if (i_en) begin
                if (i_we) begin
                    if (i_mask[gi]) begin
                        lane_mem[i_idx] <= i_wdata[8*gi +: 8];
                    end
                end else begin
                    lane_rdata_reg <= lane_mem[i_idx];
                end
            end
        end

        assign o_rdata[8*gi +: 8] = lane_rdata_reg;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request, waits a fixed latency, accesses the bank,
// and returns a one-cycle response while holding the pipeline off with busy.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    dmem_if.slave bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = 4;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;

    logic [IDX_W-1:0]    idx_reg;
    logic [WORD_W-1:0]   wdata_reg;
    logic [MASK_W-1:0]   mask_reg;
    logic                ren_reg;
    logic                wen_reg;
    logic [ERR_W-1:0]    cause_reg;

    logic                rsp_err_reg;
    logic                rdata_sel_reg;

    logic                accept;
    logic                fire;
    logic [ERR_W-1:0]    req_cause;
    logic [WORD_W-1:0]   bank_rdata;

    assign accept = (state_reg == IDLE) && bus.i_req_vld && (bus.i_req_ren || bus.i_req_wen);
    // Last WAIT cycle: the bank access and response capture happen on the coming edge
    assign fire   = (state_reg == WAIT) && (cnt_reg == '0);

    // Classify the incoming request before it is latched
    always_comb begin
        req_cause           = addr_err(bus.i_req_addr, DEPTH);
        req_cause[ERR_RDWR] = bus.i_req_ren && bus.i_req_wen;
    end

    // State and latency counter registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next state: WAIT always lasts LATENCY cycles (a single cycle when LATENCY is 1),
    // so the response lands in the cycle after accept edge + LATENCY.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = WAIT;
                    cnt_next   = CNT_W'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the request on accept; inputs are ignored for the rest of the transaction
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_reg   <= '0;
            wdata_reg <= '0;
            mask_reg  <= '0;
            ren_reg   <= 1'b0;
            wen_reg   <= 1'b0;
            cause_reg <= '0;
        end else if (accept) begin
            idx_reg   <= bus.i_req_addr[IDX_W+1:2];
            wdata_reg <= bus.i_req_wdata;
            mask_reg  <= bus.i_req_mask;
            ren_reg   <= bus.i_req_ren;
            wen_reg   <= bus.i_req_wen;
            cause_reg <= req_cause;
        end
    end

    // Response status captured alongside the bank access; held until the next response
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rsp_err_reg   <= 1'b0;
            rdata_sel_reg <= 1'b0;
        end else if (fire) begin
            rsp_err_reg   <= |cause_reg;
            rdata_sel_reg <= ren_reg && (cause_reg == '0);
        end
    end

    // Erroneous requests never touch the array
    dmem_bank #(
        .DEPTH (DEPTH)
    ) u_bank (
        .i_clk   (i_clk),
        .i_en    (fire && (cause_reg == '0)),
        .i_we    (wen_reg),
        .i_mask  (mask_reg),
        .i_idx   (idx_reg),
        .i_wdata (wdata_reg),
        .o_rdata (bank_rdata)
    );

    // Bank read data is itself registered and only refreshes on good loads, so gating it
    // with the registered select gives a held word for loads and zero for stores/errors.
    assign bus.o_busy      = (state_reg != IDLE);
    assign bus.o_rsp_vld   = (state_reg == RESP);
    assign bus.o_rsp_err   = rsp_err_reg;
    assign bus.o_rsp_rdata = rdata_sel_reg ? bank_rdata : '0;

endmodule
